spawn_scheduler: RTL and testbench

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

---
 rtl/spawn_scheduler.sv | 140 ++++++++++++++
 tb/tb_spawn_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spawn_scheduler.sv
// Spawn scheduler: waits PERIOD cycles, draws random columns (with bounded retries on
// blocked columns) and offers an unblocked one over a valid/ready handshake.
// Optional statistics counters are compiled in when SPAWN_STATS_EN is defined.
module spawn_scheduler #(
  parameter int PERIOD    = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] rnd,
  output logic       rnd_next,
  output logic       lfsr_state,
  input  logic [7:0] blocked_mask,
  output logic       spawn_valid,
  output logic [2:0] spawn_col,
  input  logic       spawn_ready,
  output logic       skip_pulse,
  output logic [7:0] spawn_cnt,
  output logic [7:0] skip_cnt
);

  typedef enum logic [2:0] {IDLE, WAIT, DRAW, SAMPLE, OFFER} state_t;

  localparam logic [7:0] RELOAD    = 8'(PERIOD - 1);
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] retry_q, retry_d;
  logic [2:0] col_q, col_d;
  logic       valid_q, valid_d;
  logic       skip_q, skip_d;
  logic       lfsr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      retry_q <= 3'd0;
      col_q   <= 3'd0;
      valid_q <= 1'b0;
      skip_q  <= 1'b0;
      lfsr_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      skip_q  <= skip_d;
      lfsr_q  <= ~run;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    col_d   = col_q;
    valid_d = valid_q;
    skip_d  = 1'b0;
    // Losing run aborts everything; a pending handshake on this edge still counts.
    if (state_q != IDLE && !run) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      retry_d = 3'd0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_d = WAIT;
            cnt_d   = RELOAD;
          end
        end
        WAIT: begin
          if (cnt_q == 8'd0) state_d = DRAW;
          else cnt_d = cnt_q - 8'd1;
        end
        DRAW: state_d = SAMPLE;
        SAMPLE: begin
          if (!blocked_mask[rnd]) begin
            col_d   = rnd;
            retry_d = 3'd0;
            valid_d = 1'b1;
            state_d = OFFER;
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 3'd1;
            state_d = DRAW;
          end else begin
            skip_d  = 1'b1;
            retry_d = 3'd0;
            cnt_d   = RELOAD;
            state_d = WAIT;
          end
        end
        OFFER: begin
          if (spawn_ready) begin
            valid_d = 1'b0;
            cnt_d   = RELOAD;
            state_d = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rnd_next    = (state_q == DRAW) && run;
  assign lfsr_state  = lfsr_q;
  assign spawn_valid = valid_q;
  assign spawn_col   = col_q;
  assign skip_pulse  = skip_q;

`ifdef SPAWN_STATS_EN
  logic [7:0] spawn_cnt_q, skip_cnt_q;
  logic       accept;

  // valid is only ever high in OFFER, so this also covers accept-with-run-low.
  assign accept = valid_q & spawn_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      spawn_cnt_q <= 8'd0;
      skip_cnt_q  <= 8'd0;
    end else begin
      if (accept && spawn_cnt_q != 8'hFF) spawn_cnt_q <= spawn_cnt_q + 8'd1;
      if (skip_d && skip_cnt_q != 8'hFF) skip_cnt_q <= skip_cnt_q + 8'd1;
    end
  end

  assign spawn_cnt = spawn_cnt_q;
  assign skip_cnt  = skip_cnt_q;
`else
  assign spawn_cnt = 8'd0;
  assign skip_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: 3-bit LFSR environment, cycle-level behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spawn_scheduler;

  localparam int PERIOD    = 8;
  localparam int MAX_RETRY = 3;

  localparam int PH_IDLE   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_DRAW   = 2;
  localparam int PH_SAMPLE = 3;
  localparam int PH_OFFER  = 4;

  logic       clk = 1'b0;
  logic       reset, run, spawn_ready;
  logic [7:0] blocked_mask;
  logic [2:0] rnd;
  logic       rnd_next, lfsr_state, spawn_valid, skip_pulse;
  logic [2:0] spawn_col;
  logic [7:0] spawn_cnt, skip_cnt;

  int n_checks = 0;
  int n_errors = 0;

  spawn_scheduler #(.PERIOD(PERIOD), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset), .run(run), .rnd(rnd), .rnd_next(rnd_next),
    .lfsr_state(lfsr_state), .blocked_mask(blocked_mask), .spawn_valid(spawn_valid),
    .spawn_col(spawn_col), .spawn_ready(spawn_ready), .skip_pulse(skip_pulse),
    .spawn_cnt(spawn_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // LFSR environment: cycle 0,4,6,3,5,2,1 starting from 000, frozen by lfsr_state.
  logic [2:0] lfsr_seq [7];
  int         lfsr_idx = 0;
  initial lfsr_seq = '{3'd0, 3'd4, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1};
  assign rnd = lfsr_seq[lfsr_idx];

  // Values captured mid-cycle, consumed at the following rising edge.
  logic       s_reset = 1'b0, s_run = 1'b0, s_ready = 1'b0, s_rnd_next = 1'b0, s_lfsr = 1'b1;
  logic [7:0] s_mask = 8'd0;
  logic [2:0] s_rnd = 3'd0;

  // Behavioural model
  int   m_phase = PH_IDLE, m_wait_left = 0, m_tries = 0, m_spawns = 0, m_skips = 0;
  logic m_valid = 1'b0, m_skip = 1'b0, m_lfsr = 1'b1;
  logic [2:0] m_col = 3'd0;
  bit   model_ok = 1'b0;

  always @(posedge clk) begin
    if (!s_reset) lfsr_idx <= 0;
    else if (s_rnd_next && !s_lfsr) lfsr_idx <= (lfsr_idx == 6) ? 0 : lfsr_idx + 1;

    if (!s_reset) begin
      m_phase = PH_IDLE; m_wait_left = 0; m_tries = 0; m_spawns = 0; m_skips = 0;
      m_valid = 1'b0; m_skip = 1'b0; m_lfsr = 1'b1; m_col = 3'd0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_skip = 1'b0;
      m_lfsr = !s_run;
      if (m_phase != PH_IDLE && !s_run) begin
        if (m_phase == PH_OFFER && s_ready && m_spawns < 255) m_spawns++;
        m_phase = PH_IDLE; m_valid = 1'b0; m_tries = 0;
      end else begin
        case (m_phase)
          PH_IDLE: if (s_run) begin m_phase = PH_WAIT; m_wait_left = PERIOD; end
          PH_WAIT: begin
            m_wait_left--;
            if (m_wait_left == 0) m_phase = PH_DRAW;
          end
          PH_DRAW: m_phase = PH_SAMPLE;
          PH_SAMPLE: begin
            if (!s_mask[s_rnd]) begin
              m_col = s_rnd; m_valid = 1'b1; m_tries = 0; m_phase = PH_OFFER;
            end else if (m_tries < MAX_RETRY) begin
              m_tries++; m_phase = PH_DRAW;
            end else begin
              m_skip = 1'b1; m_tries = 0; m_phase = PH_WAIT; m_wait_left = PERIOD;
              if (m_skips < 255) m_skips++;
            end
          end
          PH_OFFER: if (s_ready) begin
            m_valid = 1'b0; m_phase = PH_WAIT; m_wait_left = PERIOD;
            if (m_spawns < 255) m_spawns++;
          end
          default: m_phase = PH_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    s_reset = reset; s_run = run; s_ready = spawn_ready; s_mask = blocked_mask;
    s_rnd = rnd; s_rnd_next = rnd_next; s_lfsr = lfsr_state;
    if (model_ok) begin
      chk("spawn_valid", 32'(spawn_valid), 32'(m_valid));
      chk("spawn_col", 32'(spawn_col), 32'(m_col));
      chk("skip_pulse", 32'(skip_pulse), 32'(m_skip));
      chk("lfsr_state", 32'(lfsr_state), 32'(m_lfsr));
      chk("rnd_next", 32'(rnd_next), 32'((m_phase == PH_DRAW) && run));
`ifdef SPAWN_STATS_EN
      chk("spawn_cnt", 32'(spawn_cnt), 32'(m_spawns));
      chk("skip_cnt", 32'(skip_cnt), 32'(m_skips));
`else
      chk("spawn_cnt", 32'(spawn_cnt), 32'd0);
      chk("skip_cnt", 32'(skip_cnt), 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; spawn_ready = 1'b0; blocked_mask = 8'd0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // Counts edges after the next (launch) edge until spawn_valid is seen high.
  task automatic wait_valid(output int cyc, output int pulses);
    cyc = 0; pulses = 0;
    tick();
    forever begin
      @(negedge clk);
      if (rnd_next) pulses++;
      if (spawn_valid) break;
      if (cyc >= 60) begin
        chk("valid_timeout", 32'(cyc), 32'd0);
        break;
      end
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc, pulses, skips, valids, skip_at, next_pulse, mode;
    reset = 1'b0; run = 1'b0; spawn_ready = 1'b0; blocked_mask = 8'd0;

    // Basic spawn, free board
    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(spawn_valid), 32'd0);
    chk("rst_lfsr_state", 32'(lfsr_state), 32'd1);
    tick();
    run = 1'b1; spawn_ready = 1'b1;
    wait_valid(cyc, pulses);
    chk("lat_first", 32'(cyc), 32'(PERIOD + 2));
    chk("col_first", 32'(spawn_col), 32'd4);
    wait_valid(cyc, pulses);
    chk("lat_second", 32'(cyc), 32'(PERIOD + 2));
    chk("col_second", 32'(spawn_col), 32'd6);

    // One blocked draw then retry
    do_reset();
    run = 1'b1; spawn_ready = 1'b1; blocked_mask = 8'h10;
    wait_valid(cyc, pulses);
    chk("retry_pulses", 32'(pulses), 32'd2);
    chk("retry_col", 32'(spawn_col), 32'd6);
    chk("retry_lat", 32'(cyc), 32'(PERIOD + 4));

    // Everything blocked: skip after 1+MAX_RETRY draws
    do_reset();
    run = 1'b1; spawn_ready = 1'b1; blocked_mask = 8'hFF;
    tick();
    pulses = 0; skips = 0; valids = 0; skip_at = -1; next_pulse = -1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (rnd_next && skip_at < 0) pulses++;
      if (rnd_next && skip_at >= 0 && next_pulse < 0) next_pulse = c;
      if (skip_pulse) begin skips++; skip_at = c; end
      if (spawn_valid) valids++;
      tick();
    end
    chk("skip_draws", 32'(pulses), 32'(MAX_RETRY + 1));
    chk("skip_count", 32'(skips), 32'd1);
    chk("skip_no_valid", 32'(valids), 32'd0);
    chk("skip_next_gap", 32'(next_pulse - skip_at), 32'(PERIOD));
`ifdef SPAWN_STATS_EN
    chk("skip_cnt_one", 32'(skip_cnt), 32'd1);
`endif

    // Back-pressure for 5 cycles
    do_reset();
    run = 1'b1; spawn_ready = 1'b0;
    wait_valid(cyc, pulses);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(spawn_valid), 32'd1);
      chk("hold_col", 32'(spawn_col), 32'd4);
      tick();
    end
    spawn_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid", 32'(spawn_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("after_accept", 32'(spawn_valid), 32'd0);

    // run dropped mid-OFFER
    do_reset();
    run = 1'b1; spawn_ready = 1'b0;
    wait_valid(cyc, pulses);
    tick();
    run = 1'b0;
    tick();
    @(negedge clk);
    chk("drop_valid", 32'(spawn_valid), 32'd0);
    chk("drop_lfsr", 32'(lfsr_state), 32'd1);
    tick();
    run = 1'b1; spawn_ready = 1'b1;
    wait_valid(cyc, pulses);
    chk("rerun_lat", 32'(cyc), 32'(PERIOD + 2));
    chk("rerun_col", 32'(spawn_col), 32'd6);

    // Reset while in SAMPLE
    do_reset();
    run = 1'b1; spawn_ready = 1'b1;
    repeat (PERIOD + 2) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("rs_valid", 32'(spawn_valid), 32'd0);
    chk("rs_col", 32'(spawn_col), 32'd0);
    chk("rs_rnd_next", 32'(rnd_next), 32'd0);
    chk("rs_lfsr", 32'(lfsr_state), 32'd1);
    chk("rs_skip", 32'(skip_pulse), 32'd0);
    reset = 1'b1;

`ifdef SPAWN_STATS_EN
    do_reset();
    run = 1'b1; spawn_ready = 1'b1;
    repeat (300 * (PERIOD + 3) + 20) tick();
    @(negedge clk);
    chk("spawn_cnt_sat", 32'(spawn_cnt), 32'd255);
`endif

    // Randomized traffic
    do_reset();
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (i % 200 == 0) mode = $urandom_range(0, 3);
      reset       = ($urandom_range(0, 299) != 0);
      run         = ($urandom_range(0, 99) < 95);
      spawn_ready = ($urandom_range(0, 2) != 0);
      case (mode)
        0: blocked_mask = 8'h00;
        1: blocked_mask = 8'($urandom);
        2: blocked_mask = 8'hFF;
        default: blocked_mask = ~(8'd1 << $urandom_range(0, 7));
      endcase
    end
    tick();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
